// File: rtl/sub_pkg.sv
// Shared defaults and helpers for the sub2 N-channel round-robin serializer.
package sub_pkg;

  localparam int DEF_NCH  = 3;
  localparam int DEF_W    = 8;
  localparam int DEF_CNTW = 16;

  typedef logic [$clog2(DEF_NCH)-1:0] ch_idx_t;

  // Modulo increment of a channel index; wraps to 0 after nch-1.
  function automatic int rr_next(input int ptr, input int nch);
    return (ptr + 1 >= nch) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin from ptr.
module rr_arbiter
  import sub_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int IDXW = $clog2(DEF_NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] ptr,
  input  logic            mode_rr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [IDXW-1:0] gnt_idx
);

  always_comb begin
    int   base;
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    base    = mode_rr ? int'(ptr) : 0;
    idx     = 0;
    // Scan all channels once, starting at base and wrapping.
    for (int k = 0; k < NCH; k++) begin
      idx = base + k;
      if (idx >= NCH) idx = idx - NCH;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/sub2_rr_mux.sv
// N-channel arbiter/serializer onto one registered valid/ready output slot,
// with per-channel saturating grant counters.
module sub2_rr_mux
  import sub_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int W    = DEF_W,
  parameter int CNTW = DEF_CNTW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode_rr,
  input  logic                      clr_cnt,
  input  logic [NCH-1:0]            in_valid,
  output logic [NCH-1:0]            in_ready,
  input  logic [W-1:0]              in_data [NCH],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out_data,
  output logic [$clog2(NCH)-1:0]    out_ch,
  output logic [NCH-1:0][CNTW-1:0]  grant_cnt
);

  localparam int IDXW = $clog2(NCH);
  typedef logic [IDXW-1:0] idx_t;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready is one-hot (or zero) and only offered when the slot is free.
  logic                     r_out_valid;
  logic [W-1:0]             r_out_data;
  idx_t                     r_out_ch;
  idx_t                     r_ptr;
  logic [NCH-1:0][CNTW-1:0] r_cnt;

  logic                     w_free;
  logic [NCH-1:0]           w_gnt;
  idx_t                     w_gnt_idx;
  logic                     w_accept;
  logic [W-1:0]             w_sel_data;

  assign w_free = !r_out_valid || out_ready;

  rr_arbiter #(.NCH(NCH), .IDXW(IDXW)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .mode_rr (mode_rr),
    .en      (w_free && !rst),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_accept = |(w_gnt & in_valid);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt[i]) w_sel_data = in_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_free) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_ch    <= w_gnt_idx;
        r_ptr       <= idx_t'(rr_next(int'(w_gnt_idx), NCH));
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // A clear in the same cycle as an accept takes precedence.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_gnt[i] && in_valid[i] && (r_cnt[i] != {CNTW{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign in_ready  = w_gnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_sub2_rr_mux.sv
// Directed bench for sub2_rr_mux: behavioural model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_sub2_rr_mux;

  localparam int NCH  = 3;
  localparam int W    = 8;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     mode_rr;
  logic                     clr_cnt;
  logic [NCH-1:0]           in_valid;
  logic [NCH-1:0]           in_ready;
  logic [W-1:0]             in_data [NCH];
  logic                     out_valid;
  logic                     out_ready;
  logic [W-1:0]             out_data;
  logic [1:0]               out_ch;
  logic [NCH-1:0][CNTW-1:0] grant_cnt;

  sub2_rr_mux #(.NCH(NCH), .W(W), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_rr   (mode_rr),
    .clr_cnt   (clr_cnt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .grant_cnt (grant_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_valid = 0;
  int m_data  = 0;
  int m_ch    = 0;
  int m_ptr   = 0;
  int m_cnt [NCH];

  // Winner chosen by the stated rule: scan channels in priority order.
  function automatic int winner();
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = mode_rr ? (m_ptr + k) % NCH : k;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_ready();
    int g;
    if (rst) return 0;
    if (m_valid != 0 && !out_ready) return 0;
    g = winner();
    return (g < 0) ? 0 : (1 << g);
  endfunction

  function automatic int exp_cnt_packed();
    int v = 0;
    for (int i = 0; i < NCH; i++) v = v | (m_cnt[i] << (i * CNTW));
    return v;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else begin
      g = -1;
      if (m_valid == 0 || out_ready) begin
        g = winner();
        if (g >= 0) begin
          m_valid = 1;
          m_data  = int'(in_data[g]);
          m_ch    = g;
          m_ptr   = (g + 1) % NCH;
        end else begin
          m_valid = 0;
        end
      end
      if (clr_cnt) begin
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end else if (g >= 0 && m_cnt[g] < CMAX) begin
        m_cnt[g] = m_cnt[g] + 1;
      end
    end
    chk_en <= 1'b1;
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_out_valid", int'(out_valid), m_valid);
      if (m_valid != 0) begin
        chk("mdl_out_data", int'(out_data), m_data);
        chk("mdl_out_ch", int'(out_ch), m_ch);
      end
      chk("mdl_in_ready", int'(in_ready), exp_ready());
      chk("mdl_grant_cnt", int'(grant_cnt), exp_cnt_packed());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int v, input int ch, input int d);
    chk({name, "_valid"}, int'(out_valid), v);
    chk({name, "_ch"}, int'(out_ch), ch);
    chk({name, "_data"}, int'(out_data), d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; mode_rr = 1'b1; clr_cnt = 1'b0; out_ready = 1'b1;
    in_valid = 3'b111;
    in_data[0] = 8'h10; in_data[1] = 8'h11; in_data[2] = 8'h12;

    // Reset with all inputs active
    repeat (3) step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_grant_cnt", int'(grant_cnt), 0);
    rst = 1'b0;

    // Round-robin across all three channels
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("rr", 1, i % 3, 8'h10 + (i % 3));
    end
    in_valid = 3'b000;
    chk("rr_grant_cnt", int'(grant_cnt), 12'h222);

    // Clear counters while idle, then fixed priority
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("idle_out_valid", int'(out_valid), 0);
    chk("clr_grant_cnt", int'(grant_cnt), 0);
    mode_rr = 1'b0;
    in_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("fx", 1, 0, 8'h10);
      chk("fx_in_ready", int'(in_ready), 3'b001);
    end
    chk("fx_grant_cnt", int'(grant_cnt), 12'h006);

    // Mode switch: pointer kept at 1
    mode_rr = 1'b1;
    step();
    expect_out("sw", 1, 1, 8'h11);

    // Backpressure holds the slot
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("bp", 1, 1, 8'h11);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_grant_cnt", int'(grant_cnt), 12'h016);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 3'b100);
    step();
    expect_out("bp_rel", 1, 2, 8'h12);

    // Saturation on channel 1
    in_valid = 3'b010;
    repeat (20) step();
    chk("sat_cnt1", int'(grant_cnt[1]), 15);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    expect_out("clr_acc", 1, 1, 8'h11);
    chk("clr_acc_cnt", int'(grant_cnt), 0);

    // Reset mid-stream with ptr = 2 and a held output
    rst = 1'b1;
    in_valid = 3'b111;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    step();
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_ch", int'(out_ch), 0);
    rst = 1'b0;
    step();
    expect_out("post_rst", 1, 0, 8'h10);

    // Withdrawn valid is skipped in round-robin
    in_valid = 3'b100;
    step();
    expect_out("skip", 1, 2, 8'h12);

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
